// File: rtl/add_sub_mc.sv
// add_sub_mc: multi-cycle adder/subtractor.
// Runs WIDTH-bit a+b+cin or a-b-cin through one CHUNK-bit carry-lookahead
// slice per clock. The carry between slices lives in a register. Valid/ready
// handshakes on both sides; signed-overflow and zero flags come with the result.
module add_sub_mc #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Refuse to elaborate with a slice width that does not tile the operand.
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("add_sub_mc: WIDTH must be a multiple of CHUNK and CHUNK must be >= 1");
    end

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             c_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bx_reg;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] bx_sl;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   cc;
    logic [CHUNK-1:0] sum_sl;
    logic [WIDTH-1:0] s_next;

    // Handshake outputs are pure functions of state, so no input reaches an output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s         = s_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

    // One carry-lookahead slice: generate/propagate from the selected bits, carries from c_reg, then the sum.
    always_comb begin
        a_sl   = a_reg[idx*CHUNK +: CHUNK];
        bx_sl  = bx_reg[idx*CHUNK +: CHUNK];
        g      = a_sl & bx_sl;
        p      = a_sl | bx_sl;
        cc     = '0;
        cc[0]  = c_reg;
        for (int k = 0; k < CHUNK; k++) begin
            cc[k+1] = g[k] | (p[k] & cc[k]);
        end
        sum_sl = a_sl ^ bx_sl ^ cc[CHUNK-1:0];
        s_next = s_reg;
        s_next[idx*CHUNK +: CHUNK] = sum_sl;
    end

    // Control FSM plus operand, carry, result and flag registers; the flags are captured with the last slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            c_reg    <= 1'b0;
            a_reg    <= '0;
            bx_reg   <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        bx_reg <= b ^ {WIDTH{ctrl}};
                        c_reg  <= cin ^ ctrl;
                        idx    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    s_reg <= s_next;
                    c_reg <= cc[CHUNK];
                    idx   <= idx + IDXW'(1);
                    if (idx == LAST_IDX) begin
                        cout_reg <= cc[CHUNK];
                        ovf_reg  <= cc[CHUNK] ^ cc[CHUNK-1];
                        zero_reg <= (s_next == '0);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_mc.sv
// tb_add_sub_mc: directed and randomized checks of add_sub_mc against an
// integer-arithmetic reference model (WIDTH=16, CHUNK=4).
module tb_add_sub_mc;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NSLICE = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    int vector_count = 0;
    int miscompares  = 0;

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    add_sub_mc #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Hard stop in case the bench itself ever wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result {cout, ovf, zero, s} from plain unsigned/signed integer arithmetic.
    function automatic logic [18:0] refModel(input logic [15:0] ra, input logic [15:0] rb,
                                             input logic rcin, input logic rctrl);
        logic signed [15:0] sa16;
        logic signed [15:0] sb16;
        int ua, ub, sa, sb, ur, sr;
        logic [15:0] rs;
        logic rc, ro, rz;
        sa16 = ra;
        sb16 = rb;
        ua = int'(ra);
        ub = int'(rb);
        sa = sa16;
        sb = sb16;
        if (!rctrl) begin
            ur = ua + ub + int'(rcin);
            sr = sa + sb + int'(rcin);
            rc = (ur >= 65536);
        end else begin
            ur = ua - ub - int'(rcin);
            sr = sa - sb - int'(rcin);
            rc = (ur >= 0);
        end
        rs = ur[15:0];
        ro = (sr > 32767) || (sr < -32768);
        rz = (rs == 16'h0000);
        return {rc, ro, rz, rs};
    endfunction

    // Issue one operation, check latency and results, hold back-pressure for 'hold' cycles, then drain.
    task automatic applyStimulus(input logic [15:0] op_a, input logic [15:0] op_b,
                                 input logic op_cin, input logic op_ctrl,
                                 input int hold, input string tag);
        logic [18:0] expv;
        int lat;
        int guard;
        expv = refModel(op_a, op_b, op_cin, op_ctrl);
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        ctrl     = op_ctrl;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
        ctrl     = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'(NSLICE));
        if (!out_valid) begin
            return;
        end
        checkOutput({tag, ".s"},    32'(s),    32'(expv[15:0]));
        checkOutput({tag, ".cout"}, 32'(cout), 32'(expv[18]));
        checkOutput({tag, ".ovf"},  32'(ovf),  32'(expv[17]));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(expv[16]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = 16'hAAAA;
            b        = 16'hAAAA;
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, ".bp_in_ready"},  32'(in_ready),  32'd0);
            checkOutput({tag, ".bp_out_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ".bp_s"},         32'(s),         32'(expv[15:0]));
            checkOutput({tag, ".bp_flags"},     32'({cout, ovf, zero}), 32'(expv[18:16]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, ".post_in_ready"},  32'(in_ready),  32'd1);
        checkOutput({tag, ".post_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Main sequence: reset, test-plan vectors, back-pressure, mid-operation reset, random traffic.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        ctrl      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.s",         32'(s),         32'd0);
        checkOutput("reset.flags",     32'({cout, ovf, zero}), 32'd0);
        rst = 1'b0;

        applyStimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, "add");
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "sub_neg");
        applyStimulus(16'h0010, 16'h0005, 1'b1, 1'b1, 0, "sub_borrow");
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "ovf_add");
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "ovf_sub");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "wrap_zero");
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1, 0, "sub_zero");
        applyStimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0, 5, "backpressure");

        @(negedge clk);
        a        = 16'h1234;
        b        = 16'h0FFF;
        cin      = 1'b0;
        ctrl     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst.in_ready",  32'(in_ready),  32'd1);
        checkOutput("midrst.s",         32'(s),         32'd0);
        checkOutput("midrst.flags",     32'({cout, ovf, zero}), 32'd0);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "after_rst");

        for (int n = 0; n < 40; n++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompares);
        $finish;
    end

endmodule
